// File: rtl/spm_boot_loader_pkg.sv
// Shared types and defaults for the RISC_SPM boot loader.
// The default word size matches the one used by RISC_SPM.
package spm_boot_loader_pkg;

   localparam int WORD_SIZE_DEF  = 8;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int WR_PULSE_DEF   = 2;
   localparam int RST_HOLD_DEF   = 4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR_A,
      S_HDR_N,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_HOLD,
      S_DONE,
      S_ERR
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spm_boot_loader_if.sv
// Stream-in and memory-write bundle between a load source, the loader and RISC_SPM.
// The slave modport is the loader side; the master modport is the driver/observer side.
interface spm_boot_loader_if #(
   parameter int WORD_SIZE  = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic [WORD_SIZE-1:0]  in_data;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_SIZE-1:0]  mem_data;
   logic                  mem_write;
   logic                  cpu_hold;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, mem_addr, mem_data, mem_write, cpu_hold, busy, done, err
   );

   modport master (
      output start, in_valid, in_data,
      input  in_ready, mem_addr, mem_data, mem_write, cpu_hold, busy, done, err
   );
endinterface

// File: rtl/spm_boot_loader_pulse_timer.sv
// Loadable down-counter with a zero flag; times both the write pulse and the CPU hold.
module spm_boot_loader_pulse_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);
endmodule

// File: rtl/spm_boot_loader.sv
// Loads a checksummed program image into RISC_SPM memory and holds the CPU
// in reset until the whole image has been written and verified.
module spm_boot_loader
   import spm_boot_loader_pkg::*;
#(
   parameter int WORD_SIZE  = WORD_SIZE_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int WR_PULSE   = WR_PULSE_DEF,
   parameter int RST_HOLD   = RST_HOLD_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   spm_boot_loader_if.slave     bus
);
   localparam int TMR_MAX = max2(WR_PULSE, RST_HOLD);
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
   logic [WORD_SIZE-1:0]  count_q, count_d;
   logic [WORD_SIZE-1:0]  csum_q, csum_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_SIZE-1:0]  mem_data_q, mem_data_d;
   logic                  mem_write_q, mem_write_d;
   logic                  in_ready_q, in_ready_d;
   logic                  busy_q, busy_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  tmr_load;
   logic [TMR_W-1:0]      tmr_val;
   logic                  tmr_zero;
   logic                  xfer;

   assign xfer = bus.in_valid & in_ready_q;

   spm_boot_loader_pulse_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d     = state_q;
      addr_ptr_d  = addr_ptr_q;
      count_d     = count_q;
      csum_d      = csum_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      mem_write_d = mem_write_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
               csum_d  = '0;
               state_d = S_HDR_A;
            end
         end
         S_HDR_A: begin
            if (xfer) begin
               addr_ptr_d = bus.in_data[ADDR_WIDTH-1:0];
               csum_d     = csum_q + bus.in_data;
               state_d    = S_HDR_N;
            end
         end
         S_HDR_N: begin
            if (xfer) begin
               count_d = bus.in_data;
               csum_d  = csum_q + bus.in_data;
               state_d = (bus.in_data == '0) ? S_CSUM : S_DATA;
            end
         end
         S_DATA: begin
            // Timer is loaded one short so the pulse spans exactly WR_PULSE cycles.
            if (xfer) begin
               mem_addr_d  = addr_ptr_q;
               mem_data_d  = bus.in_data;
               mem_write_d = 1'b1;
               csum_d      = csum_q + bus.in_data;
               tmr_load    = 1'b1;
               tmr_val     = TMR_W'(WR_PULSE - 1);
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            if (tmr_zero) begin
               mem_write_d = 1'b0;
               addr_ptr_d  = addr_ptr_q + ADDR_WIDTH'(1);
               count_d     = count_q - WORD_SIZE'(1);
               state_d     = (count_q == WORD_SIZE'(1)) ? S_CSUM : S_DATA;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               if (bus.in_data == csum_q) begin
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(RST_HOLD - 1);
                  state_d  = S_HOLD;
               end else begin
                  state_d  = S_ERR;
               end
            end
         end
         S_HOLD: begin
            if (tmr_zero) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Status outputs are decoded from the next state so they register in step with it.
      in_ready_d = (state_d inside {S_HDR_A, S_HDR_N, S_DATA, S_CSUM});
      busy_d     = (state_d inside {S_HDR_A, S_HDR_N, S_DATA, S_WRITE, S_CSUM, S_HOLD});
      cpu_hold_d = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_ptr_q  <= '0;
         count_q     <= '0;
         csum_q      <= '0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_write_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         cpu_hold_q  <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_ptr_q  <= addr_ptr_d;
         count_q     <= count_d;
         csum_q      <= csum_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         mem_write_q <= mem_write_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         cpu_hold_q  <= cpu_hold_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_data  = mem_data_q;
   assign bus.mem_write = mem_write_q;
   assign bus.cpu_hold  = cpu_hold_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule
